// File: rtl/sw_scoring_array_v2.sv
// sw_scoring_array_v2: Smith-Waterman affine-gap local alignment scorer on a LENGTH-PE systolic array
// Ports: clk; rst (async, active-low); q_load/q_data/q_len + match/mismatch/gap_open/gap_extend load a job in IDLE;
// t_valid/t_ready/t_base/t_last stream target bases; res_valid/res_ready/res_score/res_ovf return the held result.
module sw_scoring_array_v2 #(
  parameter int SCORE_WIDTH = 12,
  parameter int LENGTH = 32,
  parameter int LOG_LENGTH = $clog2(LENGTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    q_load,
  input  logic [2*LENGTH-1:0]     q_data,
  input  logic [LOG_LENGTH:0]     q_len,
  input  logic [SCORE_WIDTH-1:0]  match,
  input  logic [SCORE_WIDTH-1:0]  mismatch,
  input  logic [SCORE_WIDTH-1:0]  gap_open,
  input  logic [SCORE_WIDTH-1:0]  gap_extend,
  input  logic                    t_valid,
  output logic                    t_ready,
  input  logic [1:0]              t_base,
  input  logic                    t_last,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [SCORE_WIDTH-1:0]  res_score,
  output logic                    res_ovf
);
  localparam int SW = SCORE_WIDTH;
  localparam int QW = LOG_LENGTH + 1;
  localparam logic [SW-1:0] SMAX = '1;
  localparam logic [QW-1:0] LEN_Q = QW'(LENGTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t st, nxt;
  logic [QW-1:0] cnt, ql_r;
  logic [2*LENGTH-1:0] q_r;
  logic [SW-1:0] m_r, mm_r, go_r, ge_r, best;
  logic ovf, accept, clr;
  logic [LOG_LENGTH-1:0] sel;
  logic [SW-1:0] h_o[LENGTH], f_o[LENGTH], mx_o[LENGTH];
  logic [1:0] b_o[LENGTH];
  logic [LENGTH-1:0] v_o, sat;
  function automatic logic [SW-1:0] mx2(input logic [SW-1:0] a, input logic [SW-1:0] b);
    return a > b ? a : b;
  endfunction
  function automatic logic [SW-1:0] fl(input logic [SW-1:0] a, input logic [SW-1:0] b);
    return a > b ? a - b : '0;
  endfunction
  assign accept = st == RUN && t_valid;
  assign clr = st == DONE && res_ready;
  assign t_ready = st == RUN;
  assign res_valid = st == DONE;
  assign res_score = best;
  assign res_ovf = ovf;
  assign sel = LOG_LENGTH'(ql_r - QW'(1));
  always_comb begin
    nxt = st;
    nxt = (st == IDLE && q_load) ? RUN :
          (accept && t_last) ? DRAIN :
          (st == DRAIN && cnt == '0) ? DONE :
          clr ? IDLE : st;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      cnt <= '0;
      q_r <= '0;
      ql_r <= '0;
      m_r <= '0;
      mm_r <= '0;
      go_r <= '0;
      ge_r <= '0;
      best <= '0;
      ovf <= 1'b0;
    end else begin
      st <= nxt;
      if (st == IDLE && q_load) begin
        q_r <= q_data;
        ql_r <= (q_len == '0 || q_len > LEN_Q) ? LEN_Q : q_len;
        m_r <= match;
        mm_r <= mismatch;
        go_r <= gap_open;
        ge_r <= gap_extend;
      end
      cnt <= (accept && t_last) ? ql_r : (st == DRAIN && cnt != '0) ? cnt - QW'(1) : cnt;
      best <= clr ? '0 : v_o[sel] ? mx2(best, mx_o[sel]) : best;
      ovf <= clr ? 1'b0 : ovf | (|sat);
    end
  end
  for (genvar i = 0; i < LENGTH; i++) begin : g_pe
    logic [SW-1:0] l, fin, mxin, e_n, f_n, s, h_n, h, e, f, d, mx;
    logic [SW:0] sum;
    logic [1:0] bin, b;
    logic vin, eq, v;
    if (i == 0) begin : g_first
      assign vin = accept;
      assign bin = t_base;
      assign l = '0;
      assign fin = '0;
      assign mxin = '0;
    end else begin : g_next
      assign vin = v_o[i-1];
      assign bin = b_o[i-1];
      assign l = h_o[i-1];
      assign fin = f_o[i-1];
      assign mxin = mx_o[i-1];
    end
    assign eq = q_r[2*i +: 2] == bin;
    assign sum = {1'b0, d} + {1'b0, m_r};
    assign s = eq ? (sum[SW] ? SMAX : sum[SW-1:0]) : fl(d, mm_r);
    assign e_n = mx2(fl(h, go_r), fl(e, ge_r));
    assign f_n = mx2(fl(l, go_r), fl(fin, ge_r));
    assign h_n = mx2(s, mx2(e_n, f_n));
    // saturation only counts for live beats in PEs that belong to the query
    assign sat[i] = vin && eq && sum[SW] && ql_r > QW'(i);
    assign h_o[i] = h;
    assign f_o[i] = f;
    assign mx_o[i] = mx;
    assign b_o[i] = b;
    assign v_o[i] = v;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst || clr) begin
        h <= '0;
        e <= '0;
        f <= '0;
        d <= '0;
        mx <= '0;
        b <= '0;
        v <= 1'b0;
      end else begin
        v <= vin;
        if (vin) begin
          h <= h_n;
          e <= e_n;
          f <= f_n;
          d <= l;
          mx <= mx2(mxin, h_n);
          b <= bin;
        end
      end
    end
  end
endmodule

// File: tb/tb_sw_scoring_array_v2.sv
// tb_sw_scoring_array_v2: scoreboard bench for sw_scoring_array_v2 with a matrix-DP reference model
module tb_sw_scoring_array_v2;
  localparam int SW = 12;
  localparam int LEN = 32;
  localparam int QW = 6;
  localparam int SMAX = 4095;
  localparam logic [1:0] BA = 2'b10;
  typedef logic [1:0] bq_t[$];
  typedef struct {int score; bit ovf; int ql;} exp_t;
  logic clk = 0, rst = 0, q_load = 0, t_valid = 0, t_last = 0, res_ready = 0;
  logic [63:0] q_data = '0;
  logic [QW-1:0] q_len = '0;
  logic [SW-1:0] match = '0, mismatch = '0, gap_open = '0, gap_extend = '0;
  logic [1:0] t_base = '0;
  logic t_ready, res_valid, res_ovf;
  logic [SW-1:0] res_score;
  exp_t sb[$];
  exp_t cur;
  int n_chk = 0, n_pass = 0, cyc = 0, acc_edge = 0, cap_s = 0;
  bit cap_o = 0, prev_v = 0;

  sw_scoring_array_v2 dut (
    .clk(clk), .rst(rst), .q_load(q_load), .q_data(q_data), .q_len(q_len),
    .match(match), .mismatch(mismatch), .gap_open(gap_open), .gap_extend(gap_extend),
    .t_valid(t_valid), .t_ready(t_ready), .t_base(t_base), .t_last(t_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_score(res_score), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [1:0] bc(input byte c);
    return (c == "A") ? 2'b10 : (c == "G") ? 2'b11 : (c == "T") ? 2'b00 : 2'b01;
  endfunction

  function automatic logic [63:0] enc(input string s, input logic [1:0] fill);
    logic [63:0] r;
    for (int i = 0; i < LEN; i++) r[2*i +: 2] = (i < s.len()) ? bc(s[i]) : fill;
    return r;
  endfunction

  function automatic bq_t tq(input string s);
    bq_t r;
    for (int i = 0; i < s.len(); i++) r.push_back(bc(s[i]));
    return r;
  endfunction

  function automatic int fl0(input int x);
    return x < 0 ? 0 : x;
  endfunction

  function automatic int imax(input int a, input int b);
    return a > b ? a : b;
  endfunction

  // Full DP matrix, row by row over target bases; H(i,-1)=E=0, H(-1,*)=F(-1,*)=0.
  function automatic void model(input logic [63:0] q, input int qlen, input bq_t t,
                                input int m, input int mm, input int go, input int ge,
                                output int best, output bit ovf);
    int hp[LEN], ep[LEN], hc[LEN], fc[LEN];
    int ql, d, l, fin, e, f, s;
    ql = (qlen == 0 || qlen > LEN) ? LEN : qlen;
    best = 0;
    ovf = 0;
    for (int i = 0; i < LEN; i++) begin
      hp[i] = 0; ep[i] = 0; hc[i] = 0; fc[i] = 0;
    end
    foreach (t[j]) begin
      for (int i = 0; i < ql; i++) begin
        d = (i == 0) ? 0 : hp[i-1];
        l = (i == 0) ? 0 : hc[i-1];
        fin = (i == 0) ? 0 : fc[i-1];
        e = imax(fl0(hp[i] - go), fl0(ep[i] - ge));
        f = imax(fl0(l - go), fl0(fin - ge));
        if (q[2*i +: 2] == t[j]) begin
          s = d + m;
          if (s > SMAX) begin
            s = SMAX;
            ovf = 1;
          end
        end else s = fl0(d - mm);
        hc[i] = imax(imax(0, s), imax(e, f));
        fc[i] = f;
        ep[i] = e;
        best = imax(best, hc[i]);
      end
      for (int i = 0; i < ql; i++) hp[i] = hc[i];
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) prev_v = 0;
    else begin
      if (t_valid && t_ready && t_last) acc_edge = cyc + 1;
      if (res_valid) begin
        if (!prev_v) begin
          cap_s = res_score;
          cap_o = res_ovf;
          if (sb.size() == 0) check("spurious_result", 1, 0);
          else check("latency", cyc - acc_edge, sb[0].ql + 1);
        end else begin
          check("hold_score", res_score, cap_s);
          check("hold_ovf", res_ovf, cap_o);
        end
        if (res_ready && sb.size() > 0) begin
          cur = sb.pop_front();
          check("res_score", res_score, cur.score);
          check("res_ovf", res_ovf, cur.ovf);
        end
      end
      prev_v = res_valid;
    end
  end

  task automatic run_job(input logic [63:0] q, input int qlen, input int m, input int mm,
                         input int go, input int ge, input bq_t t, input bit gaps,
                         input int hold, input int es, input bit eo);
    exp_t e;
    int w;
    e.score = es;
    e.ovf = eo;
    e.ql = (qlen == 0 || qlen > LEN) ? LEN : qlen;
    sb.push_back(e);
    @(posedge clk); #1;
    q_data = q;
    q_len = QW'(qlen);
    match = SW'(m);
    mismatch = SW'(mm);
    gap_open = SW'(go);
    gap_extend = SW'(ge);
    q_load = 1;
    @(posedge clk); #1;
    q_load = 0;
    foreach (t[k]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      t_valid = 1;
      t_base = t[k];
      t_last = (k == t.size() - 1);
      w = 0;
      @(negedge clk);
      while (!t_ready && w < 50) begin @(negedge clk); w++; end
      if (!t_ready) check("t_ready_timeout", 0, 1);
      @(posedge clk); #1;
      t_valid = 0;
      t_last = 0;
    end
    w = 0;
    while (!res_valid && w < 300) begin @(negedge clk); w++; end
    if (!res_valid) begin
      check("res_timeout", 0, 1);
      sb.delete();
      rst = 0;
      #20 rst = 1;
    end else begin
      @(posedge clk);
      repeat (hold) @(posedge clk);
      #1 res_ready = 1;
      @(posedge clk); #1;
      res_ready = 0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run still active, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t t;
    logic [63:0] q;
    int n, m, mm, go, ge, ql, es;
    bit eo;
    @(negedge clk);
    check("reset_t_ready", t_ready, 0);
    check("reset_res_valid", res_valid, 0);
    check("reset_res_score", res_score, 0);
    check("reset_res_ovf", res_ovf, 0);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    check("idle_t_ready", t_ready, 0);
    run_job(enc("ACGT", BA), 4, 2, 1, 3, 1, tq("ACGT"), 0, 0, 8, 0);
    run_job(enc("ACGT", BA), 4, 2, 1, 3, 1, tq("TTTT"), 0, 0, 2, 0);
    run_job(enc("ACGTACGT", BA), 8, 2, 1, 3, 1, tq("ACGACGT"), 0, 0, 11, 0);
    run_job(enc("AC", BA), 2, 2, 1, 3, 1, tq("AAAA"), 0, 0, 2, 0);
    run_job(enc("AC", BA), 2, 2, 1, 3, 1, tq("AAAA"), 1, 0, 2, 0);
    run_job(enc("", BA), 32, 4000, 1, 3, 1, tq("AA"), 0, 0, 4095, 1);
    run_job(enc("ACGT", BA), 4, 2, 1, 3, 1, tq("ACGT"), 0, 10, 8, 0);
    @(posedge clk); #1;
    q_data = enc("ACGT", BA);
    q_len = 4;
    q_load = 1;
    @(posedge clk); #1;
    q_load = 0;
    t_valid = 1;
    t_base = BA;
    t_last = 0;
    repeat (3) @(posedge clk);
    #3 rst = 0;
    #1;
    check("rst_mid_t_ready", t_ready, 0);
    check("rst_mid_res_valid", res_valid, 0);
    check("rst_mid_res_score", res_score, 0);
    t_valid = 0;
    @(posedge clk); #1 rst = 1;
    run_job(enc("ACGT", BA), 4, 2, 1, 3, 1, tq("ACGT"), 0, 0, 8, 0);
    for (int k = 0; k < 24; k++) begin
      t = {};
      n = $urandom_range(1, 40);
      for (int j = 0; j < n; j++) t.push_back(2'($urandom_range(0, 3)));
      q = {$urandom, $urandom};
      ql = $urandom_range(0, 40);
      m = (k % 5 == 0) ? $urandom_range(1000, 4095) : $urandom_range(0, 15);
      mm = $urandom_range(0, 15);
      go = $urandom_range(0, 15);
      ge = $urandom_range(0, 7);
      model(q, ql, t, m, mm, go, ge, es, eo);
      run_job(q, ql, m, mm, go, ge, t, 1'($urandom_range(0, 1)), $urandom_range(0, 3), es, eo);
    end
    repeat (5) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
